muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle over a shared {hi,lo} shift register and one adder.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    op_e             op_q;
    logic [XLEN-1:0] a_q, b_q, hi_q, lo_q, result_q;
    logic            qneg_q, rneg_q;
    logic [CW-1:0]   cnt_q;

    op_e             op_in;
    logic            sdiv_in, an_in, bn_in;
    logic [XLEN-1:0] a_mag_d, b_mag_d, sel_d;
    logic            last_d, a_sgn_d;
    logic [XLEN:0]   alu_a, alu_b, alu_y;
    logic            alu_sub;

    always_comb begin
        op_in   = op_e'(funct3);
        sdiv_in = funct3[2] & ~funct3[0];
        an_in   = sdiv_in & op_a[XLEN-1];
        bn_in   = sdiv_in & op_b[XLEN-1];
        a_mag_d = an_in ? (~op_a + 1'b1) : op_a;
        b_mag_d = bn_in ? (~op_b + 1'b1) : op_b;
    end

    // One adder/subtractor: a mul or div step while iterating, and on the
    // final CALC cycle it computes 0 +/- selected word for the sign fixup.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sub = 1'b0;
        sel_d   = '0;
        last_d  = (cnt_q == CW'(XLEN));
        a_sgn_d = (op_q == OP_MULH) || (op_q == OP_MULHSU);
        if (last_d) begin
            if (is_div(op_q)) begin
                sel_d   = op_q[1] ? hi_q : lo_q;
                alu_sub = op_q[1] ? rneg_q : qneg_q;
            end else begin
                sel_d   = (op_q == OP_MUL) ? lo_q : hi_q;
            end
            alu_b = {1'b0, sel_d};
        end else if (is_div(op_q)) begin
            alu_a   = {hi_q, lo_q[XLEN-1]};
            alu_b   = {1'b0, b_q};
            alu_sub = 1'b1;
        end else begin
            // Signed multiplier: its MSB weighs -2^(XLEN-1), so the last step subtracts.
            alu_a   = {a_sgn_d & hi_q[XLEN-1], hi_q};
            alu_b   = lo_q[0] ? {a_sgn_d & a_q[XLEN-1], a_q} : '0;
            alu_sub = (op_q == OP_MULH) && (cnt_q == CW'(XLEN - 1));
        end
        alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    op_q  <= op_in;
                    cnt_q <= '0;
                    hi_q  <= '0;
                    a_q   <= op_a;
                    if (is_div(op_in)) begin
                        b_q    <= b_mag_d;
                        lo_q   <= a_mag_d;
                        qneg_q <= an_in ^ bn_in;
                        rneg_q <= an_in;
                        if (op_b == '0) begin
                            result_q <= funct3[1] ? op_a : '1;
                            state_q  <= S_FINISH;
                        end else if (sdiv_in && op_a == MINV && op_b == '1) begin
                            result_q <= funct3[1] ? '0 : op_a;
                            state_q  <= S_FINISH;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end else begin
                        b_q     <= op_b;
                        lo_q    <= op_b;
                        qneg_q  <= 1'b0;
                        rneg_q  <= 1'b0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: if (last_d) begin
                    result_q <= alu_y[XLEN-1:0];
                    state_q  <= S_FINISH;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                    if (is_div(op_q)) begin
                        // Restore on borrow; quotient bit is the inverted borrow.
                        hi_q <= alu_y[XLEN] ? alu_a[XLEN-1:0] : alu_y[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], ~alu_y[XLEN]};
                    end else begin
                        hi_q <= alu_y[XLEN:1];
                        lo_q <= {alu_y[0], lo_q[XLEN-1:1]};
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_FINISH);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32) against a 64-bit arithmetic model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges counted from the one that samples start (inclusive) to done:
    // a full operation is XLEN+2; a bypassed divide finishes right after start.
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 2;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(f, a, b);
        wait_done(n);
        chk({tag, "_lat"}, 64'(n + 1), 64'(ref_lat(f, a, b)));
        chk({tag, "_res"}, {32'b0, result}, {32'b0, ref_res(f, a, b)});
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, gap, dcount;
        logic [31:0] held;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh_min", 3'b001, MINV, MINV);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7);
        run_op("divu_by0", 3'b101, 32'd5, 32'd0);
        run_op("rem_by0", 3'b110, 32'd5, 32'd0);
        run_op("div_ovf", 3'b100, MINV, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'b110, MINV, 32'hFFFF_FFFF);
        run_op("div_0by0", 3'b100, 32'd0, 32'd0);

        for (int i = 0; i < 60; i++)
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());

        // start while busy must not disturb the running multiply
        issue(3'b000, 32'd7, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; funct3 = 3'b101; op_a = 32'd99; op_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("midstart_res", {32'b0, result}, 64'd21);
        @(posedge clk); #1;
        chk("midstart_idle", {63'b0, busy}, 64'd0);

        // flush in CALC: idle next cycle, no done, result unchanged
        held = result;
        issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            @(posedge clk); #1;
        end
        chk("flush_nodone", 64'(dcount), 64'd0);
        chk("flush_result", {32'b0, result}, {32'b0, held});

        // flush beats start in the same idle cycle
        flush = 1'b1;
        issue(3'b000, 32'd2, 32'd2);
        flush = 1'b0;
        chk("flush_start_busy", {63'b0, busy}, 64'd0);

        // reset in the middle of CALC
        issue(3'b100, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_result", {32'b0, result}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);

        // back-to-back: second start held high during the first done
        issue(3'b000, 32'd6, 32'd7);
        wait_done(n);
        chk("b2b_first", {32'b0, result}, 64'd42);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        gap = 2;
        wait_done(n);
        gap += n;
        chk("b2b_gap", 64'(gap), 64'(XLEN + 3));
        chk("b2b_second", {32'b0, result}, 64'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
